// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - ROM, redirect and decode-side signals of the fetch sequencer
interface fetch_ctrl_if #(
  parameter int ADDRESS_WIDTH     = 8,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0]     imem_addr;
  logic [INSTRUCTION_WIDTH-1:0] imem_rd;
  logic                         redirect_valid;
  logic [ADDRESS_WIDTH-1:0]     redirect_pc;
  logic                         halt;
  logic                         out_valid;
  logic                         out_ready;
  logic [INSTRUCTION_WIDTH-1:0] out_instr;
  logic [ADDRESS_WIDTH-1:0]     out_pc;
  logic                         misalign_err;

  // Fetch controller side
  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output misalign_err
  );

  // ROM / PC path / decode side
  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with prefetch queue; optional FETCH_ALIGN_CHECK_EN
module fetch_ctrl #(
  parameter int                     ADDRESS_WIDTH     = 8,
  parameter int                     INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC        = '0,
  parameter int                     QUEUE_DEPTH       = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0]     pc_mem    [QUEUE_DEPTH];
  logic                         push;
  logic                         pop;
  logic                         room;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign bus.misalign_err = err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.imem_addr = pc_q;
  // Valid comes from registered occupancy only, so no combinational path from ready/redirect.
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = instr_mem[rd_ptr_q];
  assign bus.out_pc    = pc_mem[rd_ptr_q];

  // Handshake decode and next-state for PC, pointers, occupancy and error flag
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    pop  = (count_q != '0) && bus.out_ready;
    room = (count_q < DEPTH_C) || pop;
    push = !bus.redirect_valid && !bus.halt && room
`ifdef FETCH_ALIGN_CHECK_EN
           && !err_q
`endif
           ;

    if (bus.redirect_valid) begin
      // Flush wins over everything; a same-cycle pop is still taken by decode.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_d = bus.redirect_pc;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
`else
      pc_d = bus.redirect_pc & ~ADDRESS_WIDTH'(3);
`endif
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = pc_q + ADDRESS_WIDTH'(4);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Queue storage: capture ROM word and its address at the tail on push
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rd;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] m_pc;
  logic [7:0] m_q[$];
  bit         m_err;

  fetch_ctrl_if #(.ADDRESS_WIDTH(8), .INSTRUCTION_WIDTH(32)) bus ();

  fetch_ctrl #(
    .ADDRESS_WIDTH(8),
    .INSTRUCTION_WIDTH(32),
    .RESET_PC(8'h00),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  assign bus.imem_rd = rom_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one cycle, advance the reference model, sample at the next falling edge.
  task automatic step(input logic rdy, input logic red, input logic [7:0] rpc, input logic hlt);
    bit pop;
    int sz;
    bus.out_ready      = rdy;
    bus.redirect_valid = red;
    bus.redirect_pc    = rpc;
    bus.halt           = hlt;
    sz  = m_q.size();
    pop = (sz > 0) && rdy;
    if (rst) begin
      m_pc = 8'h00;
      m_q.delete();
      m_err = 1'b0;
    end else if (red) begin
      m_q.delete();
      if (ALIGN) begin
        m_pc = rpc;
        if (rpc[1:0] != 2'b00) m_err = 1'b1;
      end else begin
        m_pc = rpc & 8'hFC;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!hlt && !m_err && (sz < 2 || pop)) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 8'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      errors++; $display("FAIL reset_addr got %h want 00", bus.imem_addr);
    end
    checks++;
    if (bus.misalign_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", bus.misalign_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] exp_pc[3] = '{8'h00, 8'h04, 8'h08};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] || bus.out_instr !== rom_word(exp_pc[i])) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc[i], rom_word(exp_pc[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_pc[3] = '{8'h00, 8'h04, 8'h08};
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.imem_addr !== 8'h08 || bus.out_pc !== 8'h00 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall got addr=%h pc=%h v=%b want addr=08 pc=00 v=1",
               bus.imem_addr, bus.out_pc, bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL bp_drain_%0d got v=%b pc=%h want v=1 pc=%h", i, bus.out_valid, bus.out_pc, exp_pc[i]);
      end
      step(1'b1, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h40, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 8'h40) begin
      errors++;
      $display("FAIL redir_flush got v=%b addr=%h want v=0 addr=40", bus.out_valid, bus.imem_addr);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h40 || bus.out_instr !== rom_word(8'h40)) begin
      errors++;
      $display("FAIL redir_first got v=%b pc=%h instr=%h want v=1 pc=40", bus.out_valid, bus.out_pc, bus.out_instr);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h44) begin
      errors++;
      $display("FAIL redir_second got v=%b pc=%h want v=1 pc=44", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc[4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    do_reset();
    step(1'b1, 1'b1, 8'hF8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] || bus.out_instr !== rom_word(exp_pc[i])) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b pc=%h want v=1 pc=%h", i, bus.out_valid, bus.out_pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h04) begin
      errors++;
      $display("FAIL halt_drain got v=%b pc=%h want v=1 pc=04", bus.out_valid, bus.out_pc);
    end
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 8'h08) begin
      errors++;
      $display("FAIL halt_empty got v=%b addr=%h want v=0 addr=08", bus.out_valid, bus.imem_addr);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h08) begin
      errors++;
      $display("FAIL halt_resume got v=%b pc=%h want v=1 pc=08", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_align();
    do_reset();
    step(1'b1, 1'b1, 8'h42, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (bus.misalign_err !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL align_err got err=%b v=%b want err=1 v=0", bus.misalign_err, bus.out_valid);
    end
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    checks++;
    if (bus.misalign_err !== 1'b0 || bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL align_clear got err=%b addr=%h want err=0 addr=00", bus.misalign_err, bus.imem_addr);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h00) begin
      errors++;
      $display("FAIL align_restart got v=%b pc=%h want v=1 pc=00", bus.out_valid, bus.out_pc);
    end
`else
    checks++;
    if (bus.misalign_err !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 8'h44) begin
      errors++;
      $display("FAIL align_force got err=%b v=%b pc=%h want err=0 v=1 pc=44",
               bus.misalign_err, bus.out_valid, bus.out_pc);
    end
`endif
  endtask

  task automatic test_random();
    logic       rdy, red, hlt;
    logic [7:0] rpc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      red = ($urandom_range(0, 11) == 0);
      hlt = ($urandom_range(0, 7) == 0);
      rpc = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) != 0) rpc = rpc & 8'hFC;
      step(rdy, red, rpc, hlt);
      checks++;
      if (bus.out_valid !== (m_q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_valid cyc %0d got %b want %b", i, bus.out_valid, (m_q.size() != 0));
      end
      checks++;
      if (bus.imem_addr !== m_pc || bus.misalign_err !== m_err) begin
        errors++;
        $display("FAIL rnd_pc cyc %0d got addr=%h err=%b want addr=%h err=%b",
                 i, bus.imem_addr, bus.misalign_err, m_pc, m_err);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (bus.out_pc !== m_q[0] || bus.out_instr !== rom_word(m_q[0])) begin
          errors++;
          $display("FAIL rnd_head cyc %0d got pc=%h instr=%h want pc=%h instr=%h",
                   i, bus.out_pc, bus.out_instr, m_q[0], rom_word(m_q[0]));
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.halt = 1'b0;
    m_pc = 8'h00;
    m_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
